// File: rtl/aud_recorder_if.sv
// SRAM write-port bundle driven by the recorder: one strobe carrying an address and a sample.
interface aud_recorder_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] o_address;
    logic [DATA_W-1:0] o_data;
    logic              o_write;

    modport master (output o_address, output o_data, output o_write);
    modport slave  (input  o_address, input  o_data, input  o_write);
endinterface

// File: rtl/aud_recorder.sv
// WM8731 ADC capture: deserialises the left I2S word on BCLK and writes one sample per
// frame to consecutive SRAM words, tracking recorded length and elapsed seconds.
module aud_recorder #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MAX_ADDR    = 2**20-1,
    parameter int unsigned SAMPLE_RATE = 32000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrc,
    input  logic              i_data,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    aud_recorder_if.master    sram,
    output logic              o_busy,
    output logic              o_full,
    output logic [ADDR_W:0]   o_length,
    output logic [7:0]        o_seconds
);
    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam int unsigned CNT_W = (SAMPLE_RATE > 1) ? $clog2(SAMPLE_RATE) : 1;
    localparam logic [ADDR_W-1:0] LP_MAX       = ADDR_W'(MAX_ADDR);
    localparam logic [BIT_W-1:0]  LP_LAST_BIT  = BIT_W'(DATA_W-1);
    localparam logic [CNT_W-1:0]  LP_RATE_LAST = CNT_W'(SAMPLE_RATE-1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_PAUSE, S_SHIFT, S_WRITE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_lrc_d;
    logic [DATA_W-2:0] r_shreg;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  r_smp_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_o_addr;
    logic [DATA_W-1:0] r_o_data;
    logic              r_full;
    logic [ADDR_W:0]   r_length;
    logic [7:0]        r_seconds;
    logic              w_fe;
    logic              w_write;
    logic              w_busy;
    logic              w_at_max;

    // The falling-edge cycle is the I2S delay slot; the MSB arrives one BCLK later.
    assign w_fe     = r_lrc_d & ~i_lrc;
    assign w_at_max = (r_addr == LP_MAX);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_write      = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (i_start && !i_stop) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_stop)       w_state_next = S_IDLE;
                else if (i_pause) w_state_next = S_PAUSE;
                else if (w_fe)    w_state_next = S_SHIFT;
            end
            S_PAUSE: begin
                if (i_stop)        w_state_next = S_IDLE;
                else if (!i_pause) w_state_next = S_WAIT;
            end
            S_SHIFT: begin
                if (i_stop)                        w_state_next = S_IDLE;
                else if (r_bit_cnt == LP_LAST_BIT) w_state_next = S_WRITE;
            end
            S_WRITE: begin
                w_write = 1'b1;
                if (w_at_max || i_stop) w_state_next = S_IDLE;
                else                    w_state_next = S_WAIT;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_lrc_d   <= 1'b0;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_smp_cnt <= '0;
            r_addr    <= '0;
            r_o_addr  <= '0;
            r_o_data  <= '0;
            r_full    <= 1'b0;
            r_length  <= '0;
            r_seconds <= '0;
        end else begin
            r_lrc_d <= i_lrc;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_stop) begin
                        r_addr    <= '0;
                        r_seconds <= '0;
                        r_smp_cnt <= '0;
                        r_full    <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (i_stop) r_length <= {1'b0, r_addr};
                    else if (!i_pause && w_fe) r_bit_cnt <= '0;
                end
                S_PAUSE: begin
                    if (i_stop) r_length <= {1'b0, r_addr};
                end
                S_SHIFT: begin
                    if (i_stop) begin
                        r_length <= {1'b0, r_addr};
                    end else begin
                        r_shreg   <= {r_shreg[DATA_W-3:0], i_data};
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        // Latch the finished word straight into the output so it holds after WRITE.
                        if (r_bit_cnt == LP_LAST_BIT) begin
                            r_o_data <= {r_shreg, i_data};
                            r_o_addr <= r_addr;
                        end
                    end
                end
                S_WRITE: begin
                    r_addr <= r_addr + ADDR_W'(1);
                    if (r_smp_cnt == LP_RATE_LAST) begin
                        r_smp_cnt <= '0;
                        if (r_seconds != 8'hFF) r_seconds <= r_seconds + 8'd1;
                    end else begin
                        r_smp_cnt <= r_smp_cnt + CNT_W'(1);
                    end
                    if (w_at_max || i_stop) r_length <= {1'b0, r_addr} + (ADDR_W+1)'(1);
                    if (w_at_max) r_full <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sram.o_write   = w_write;
    assign sram.o_address = r_o_addr;
    assign sram.o_data    = r_o_data;
    assign o_busy         = w_busy;
    assign o_full         = r_full;
    assign o_length       = r_length;
    assign o_seconds      = r_seconds;
endmodule

// File: tb/tb_aud_recorder.sv
// Randomised I2S bench for aud_recorder: two instances (large memory, and a 4-word memory)
// share one stimulus stream and are checked every cycle against a timestamp-based model.
module tb_aud_recorder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, lrc = 1'b1, dat = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0;
    logic nx_rst = 1'b0, nx_start = 1'b0, nx_stop = 1'b0, nx_pause = 1'b0;

    aud_recorder_if #(.ADDR_W(20), .DATA_W(16)) bus_a ();
    aud_recorder_if #(.ADDR_W(20), .DATA_W(16)) bus_b ();
    logic        busy_a, full_a, busy_b, full_b;
    logic [20:0] len_a, len_b;
    logic [7:0]  sec_a, sec_b;

    aud_recorder #(.ADDR_W(20), .DATA_W(16), .MAX_ADDR(1048575), .SAMPLE_RATE(3)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(dat), .i_start(start),
        .i_pause(pause), .i_stop(stop), .sram(bus_a), .o_busy(busy_a), .o_full(full_a),
        .o_length(len_a), .o_seconds(sec_a));

    aud_recorder #(.ADDR_W(20), .DATA_W(16), .MAX_ADDR(3), .SAMPLE_RATE(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(dat), .i_start(start),
        .i_pause(pause), .i_stop(stop), .sram(bus_b), .o_busy(busy_b), .o_full(full_b),
        .o_length(len_b), .o_seconds(sec_b));

    logic        d_wr[2], d_busy[2], d_full[2];
    logic [15:0] d_data[2];
    logic [19:0] d_addr[2];
    logic [20:0] d_len[2];
    logic [7:0]  d_sec[2];
    assign d_wr[0] = bus_a.o_write;   assign d_wr[1] = bus_b.o_write;
    assign d_data[0] = bus_a.o_data;  assign d_data[1] = bus_b.o_data;
    assign d_addr[0] = bus_a.o_address; assign d_addr[1] = bus_b.o_address;
    assign d_busy[0] = busy_a;  assign d_busy[1] = busy_b;
    assign d_full[0] = full_a;  assign d_full[1] = full_b;
    assign d_len[0] = len_a;    assign d_len[1] = len_b;
    assign d_sec[0] = sec_a;    assign d_sec[1] = sec_b;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: recording session per instance; a capture is identified by the cycle of its
    // LRCK falling edge, and the word is rebuilt from the i_data history 1..16 cycles later.
    localparam int M_OFF = 0, M_ARMED = 1, M_HELD = 2, M_CAP = 3, M_WRT = 4;
    int          m_mode[2], m_t0[2], m_addr[2], m_cnt[2], m_sec[2], m_len[2], m_oaddr[2];
    bit          m_full[2], m_wr[2];
    logic [15:0] m_data[2];
    bit          prev_lrc;
    bit          hist[64];
    int          cyc = 0;

    function automatic int max_of(input int k);
        return (k == 0) ? 1048575 : 3;
    endfunction
    function automatic int rate_of(input int k);
        return (k == 0) ? 3 : 2;
    endfunction

    task automatic model_edge();
        logic        fe;
        logic [15:0] v;
        fe = prev_lrc && !lrc;
        hist[cyc % 64] = dat;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_mode[k] = M_OFF; m_addr[k] = 0; m_cnt[k] = 0; m_sec[k] = 0; m_len[k] = 0;
                m_oaddr[k] = 0; m_full[k] = 0; m_wr[k] = 0; m_data[k] = '0;
            end else begin
                m_wr[k] = 0;
                case (m_mode[k])
                    M_OFF: if (start && !stop) begin
                        m_mode[k] = M_ARMED; m_addr[k] = 0; m_sec[k] = 0; m_cnt[k] = 0; m_full[k] = 0;
                    end
                    M_ARMED: begin
                        if (stop) begin m_len[k] = m_addr[k]; m_mode[k] = M_OFF; end
                        else if (pause) m_mode[k] = M_HELD;
                        else if (fe) begin m_mode[k] = M_CAP; m_t0[k] = cyc; end
                    end
                    M_HELD: begin
                        if (stop) begin m_len[k] = m_addr[k]; m_mode[k] = M_OFF; end
                        else if (!pause) m_mode[k] = M_ARMED;
                    end
                    M_CAP: begin
                        if (stop) begin m_len[k] = m_addr[k]; m_mode[k] = M_OFF; end
                        else if (cyc == m_t0[k] + 16) begin
                            v = '0;
                            for (int i = 1; i <= 16; i++) v = {v[14:0], hist[(m_t0[k] + i) % 64]};
                            m_wr[k] = 1; m_data[k] = v; m_oaddr[k] = m_addr[k]; m_mode[k] = M_WRT;
                        end
                    end
                    default: begin
                        m_cnt[k]++;
                        if (m_cnt[k] == rate_of(k)) begin
                            m_cnt[k] = 0;
                            if (m_sec[k] < 255) m_sec[k]++;
                        end
                        if (m_addr[k] == max_of(k)) begin
                            m_full[k] = 1; m_len[k] = max_of(k) + 1; m_mode[k] = M_OFF;
                        end else if (stop) begin
                            m_len[k] = m_addr[k] + 1; m_mode[k] = M_OFF;
                        end else m_mode[k] = M_ARMED;
                        m_addr[k]++;
                    end
                endcase
            end
        end
        prev_lrc = rst_n ? lrc : 1'b0;
        cyc++;
    endtask

    logic [19:0] wa_addr[$];
    logic [15:0] wa_data[$];
    int          nb = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("dut%0d_write", k),   d_wr[k],   m_wr[k]);
                chk($sformatf("dut%0d_data", k),    d_data[k], m_data[k]);
                chk($sformatf("dut%0d_address", k), d_addr[k], m_oaddr[k]);
                chk($sformatf("dut%0d_busy", k),    d_busy[k], m_mode[k] != M_OFF);
                chk($sformatf("dut%0d_full", k),    d_full[k], m_full[k]);
                chk($sformatf("dut%0d_length", k),  d_len[k],  m_len[k]);
                chk($sformatf("dut%0d_seconds", k), d_sec[k],  m_sec[k]);
                if (d_wr[k] === 1'b1) begin
                    $display("write dut%0d addr=%0d data=%h cyc=%0d", k, d_addr[k], d_data[k], cyc);
                    if (k == 0) begin wa_addr.push_back(d_addr[k]); wa_data.push_back(d_data[k]); end
                    else nb++;
                end
            end
        end
    end

    task automatic tick(input logic l, input logic d);
        @(negedge clk);
        rst_n = nx_rst; start = nx_start; stop = nx_stop; pause = nx_pause; lrc = l; dat = d;
        nx_start = 1'b0; nx_stop = 1'b0;
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'($urandom));
    endtask

    // One 64-BCLK frame: left word in the low-LRCK half, events injected at given bit slots.
    task automatic frame(input logic [15:0] w, input int stop_at, input int pause_at,
                         input int unpause_at, input int start_at, input int rst_at);
        for (int i = 0; i < 64; i++) begin
            if (i == stop_at)    nx_stop = 1'b1;
            if (i == start_at)   nx_start = 1'b1;
            if (i == pause_at)   nx_pause = 1'b1;
            if (i == unpause_at) nx_pause = 1'b0;
            nx_rst = (i == rst_at) ? 1'b0 : 1'b1;
            tick(logic'(i >= 32), (i >= 1 && i <= 16) ? w[16-i] : 1'($urandom));
        end
    endtask

    task automatic frm(input logic [15:0] w);
        frame(w, -1, -1, -1, -1, -1);
    endtask

    initial begin
        nx_rst = 1'b0;
        tick(1'b1, 1'b0);
        cmp_en = 1'b1;
        tick(1'b1, 1'b0);
        nx_rst = 1'b1;
        idle(3);
        #1;
        chk("reset_busy", busy_a, 0); chk("reset_len", len_a, 0); chk("reset_addr", bus_a.o_address, 0);

        nx_start = 1'b1;
        idle(1);
        frm(16'h8001); frm(16'h7FFE); frm(16'hA5A5);
        #1;
        chk("three_writes", wa_addr.size(), 3);
        if (wa_addr.size() >= 3) begin
            chk("w0_addr", wa_addr[0], 0); chk("w0_data", wa_data[0], 16'h8001);
            chk("w1_addr", wa_addr[1], 1); chk("w1_data", wa_data[1], 16'h7FFE);
            chk("w2_addr", wa_addr[2], 2); chk("w2_data", wa_data[2], 16'hA5A5);
        end

        frame(16'h1234, -1, 5, -1, -1, -1);
        #1;
        chk("inflight_write_addr", wa_addr.size() >= 4 ? wa_addr[3] : 20'hFFFFF, 3);
        chk("b_full", full_b, 1); chk("b_length", len_b, 4);
        chk("b_seconds", sec_b, 2); chk("b_busy", busy_b, 0); chk("b_writes", nb, 4);
        chk("a_seconds", sec_a, 1);
        frm(16'h0001); frm(16'h0002);
        frame(16'hDEAD, -1, -1, 0, -1, -1);
        frm(16'h0F0F);
        #1;
        chk("resume_writes", wa_addr.size(), 5);
        if (wa_addr.size() >= 5) begin
            chk("resume_addr", wa_addr[4], 4); chk("resume_data", wa_data[4], 16'h0F0F);
        end

        frame(16'hFFFF, 8, -1, -1, -1, -1);
        #1;
        chk("stop_len", len_a, 5); chk("stop_busy", busy_a, 0); chk("stop_nowrite", wa_addr.size(), 5);

        nx_start = 1'b1; nx_stop = 1'b1;
        idle(2);
        #1;
        chk("start_stop_idle", busy_a, 0);
        nx_start = 1'b1;
        idle(1);
        #1;
        chk("start_busy", busy_a, 1); chk("start_clears_full", full_b, 0);
        chk("start_keeps_len", len_b, 4); chk("start_clears_sec", sec_a, 0);
        nx_start = 1'b1;
        idle(1);
        frm(16'h5A5A);
        #1;
        if (wa_addr.size() >= 6) begin
            chk("restart_addr", wa_addr[5], 0); chk("restart_data", wa_data[5], 16'h5A5A);
        end else chk("restart_writes", wa_addr.size(), 6);

        frame(16'h1111, -1, -1, -1, -1, 6);
        #1;
        chk("midshift_reset_busy", busy_a, 0); chk("midshift_reset_len", len_a, 0);
        frm(16'h2222);
        #1;
        chk("no_write_after_reset", wa_addr.size(), 6);

        for (int f = 0; f < 40; f++) begin
            frame(16'($urandom),
                  ($urandom % 6 == 0) ? int'($urandom % 64) : -1,
                  ($urandom % 4 == 0) ? int'($urandom % 64) : -1,
                  ($urandom % 3 == 0) ? int'($urandom % 64) : -1,
                  ($urandom % 3 == 0) ? int'($urandom % 64) : -1,
                  ($urandom % 20 == 0) ? int'($urandom % 64) : -1);
        end
        idle(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
